// File: rtl/pixie_scaled_back_end_if.sv
// Framebuffer read port between the Pixie back end (master) and the framebuffer RAM (slave).
// Bus semantics: fb_read_en is a one-cycle request with no backpressure. fb_addr is valid only while fb_read_en is high.
// The slave must return fb_data in the next cycle, which is when the master samples it.
interface pixie_scaled_back_end_if #(
  parameter int FB_AW = 10
) ();
  logic             fb_read_en;
  logic [FB_AW-1:0] fb_addr;
  logic [7:0]       fb_data;

  modport master (output fb_read_en, output fb_addr, input fb_data);
  modport slave  (input fb_read_en, input fb_addr, output fb_data);
endinterface

// File: rtl/pixie_scaled_back_end.sv
// Pixie-style display back end: H/V timing, framebuffer fetch and pixel serialiser.
// Video outputs run two clocks behind the raster counters, which lines them up with the serialised pixels.
module pixie_scaled_back_end #(
  parameter int H_TOTAL   = 112,
  parameter int H_ACTIVE  = 64,
  parameter int HS_START  = 80,
  parameter int HS_WIDTH  = 12,
  parameter int V_TOTAL   = 262,
  parameter int V_ACTIVE  = 128,
  parameter int VS_START  = 182,
  parameter int VS_HEIGHT = 16,
  parameter int BPP       = 1,
  parameter int V_REPEAT  = 1,
  parameter int FB_AW     = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  pixie_scaled_back_end_if.master fb,
  output logic [BPP-1:0]          pix,
  output logic                    de,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    csync,
  output logic                    hblank,
  output logic                    vblank,
  output logic                    frame_start
);
  localparam int PPB      = 8 / BPP;
  localparam int PW       = $clog2(PPB);
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HX       = HW + 1;
  localparam int VX       = VW + 1;
  localparam int ROW_STEP = H_ACTIVE / PPB;

  generate
    if (BPP != 1 && BPP != 2 && BPP != 4) begin : g_bad_bpp
      $error("pixie_scaled_back_end: BPP must be 1, 2 or 4");
    end
    if (V_REPEAT < 1 || V_REPEAT > 4) begin : g_bad_repeat
      $error("pixie_scaled_back_end: V_REPEAT must be 1..4");
    end
    if ((H_ACTIVE % PPB) != 0 || (V_ACTIVE % V_REPEAT) != 0) begin : g_bad_active
      $error("pixie_scaled_back_end: active area not a multiple of PPB / V_REPEAT");
    end
  endgenerate

  logic [HW-1:0]    r_hc, r_h1;
  logic [VW-1:0]    r_vc, r_v1;
  logic             r_en_q, r_en1, r_s1_vld;
  logic [FB_AW-1:0] r_row_base;
  logic [1:0]       r_rep;
  logic [7:0]       r_sr;
  logic             r_de, r_hsync, r_vsync, r_csync, r_hblank, r_vblank, r_frame_start;

  logic          w_h_last, w_v_last, w_h_act, w_v_act;
  logic [HX-1:0] w_h1x;
  logic [VX-1:0] w_v1x;
  logic          w_hs, w_vs, w_hb, w_vb;

  assign w_h_last = (r_hc == HW'(H_TOTAL - 1));
  assign w_v_last = (r_vc == VW'(V_TOTAL - 1));
  assign w_h_act  = ({1'b0, r_hc} < HX'(H_ACTIVE));
  assign w_v_act  = ({1'b0, r_vc} < VX'(V_ACTIVE));

  // Raster counters, per-frame enable latch and the row base that replaces a row*width multiply.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hc       <= '0;
      r_vc       <= '0;
      r_en_q     <= 1'b0;
      r_row_base <= '0;
      r_rep      <= '0;
    end else begin
      if (w_h_last) begin
        r_hc <= '0;
        if (w_v_last) begin
          r_vc       <= '0;
          r_en_q     <= enable;
          r_row_base <= '0;
          r_rep      <= '0;
        end else begin
          r_vc <= r_vc + VW'(1);
          if (w_v_act) begin
            if (r_rep == 2'(V_REPEAT - 1)) begin
              r_rep      <= '0;
              r_row_base <= r_row_base + FB_AW'(ROW_STEP);
            end else begin
              r_rep <= r_rep + 2'd1;
            end
          end
        end
      end else begin
        r_hc <= r_hc + HW'(1);
      end
    end
  end

  assign fb.fb_read_en = r_en_q && w_h_act && w_v_act && (r_hc[PW-1:0] == '0);
  assign fb.fb_addr    = r_row_base + FB_AW'(r_hc >> PW);

  // The byte strobed at hc%PPB==0 arrives one cycle later and is loaded here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr <= '0;
    end else if (r_hc[PW-1:0] == PW'(1)) begin
      r_sr <= fb.fb_data;
    end else begin
      r_sr <= r_sr << BPP;
    end
  end

  assign w_h1x = {1'b0, r_h1};
  assign w_v1x = {1'b0, r_v1};
  assign w_hs  = (w_h1x >= HX'(HS_START)) && (w_h1x < HX'(HS_START + HS_WIDTH));
  assign w_vs  = (w_v1x >= VX'(VS_START)) && (w_v1x < VX'(VS_START + VS_HEIGHT));
  assign w_hb  = (w_h1x >= HX'(H_ACTIVE));
  assign w_vb  = (w_v1x >= VX'(V_ACTIVE));

  // The stage-1 valid bit keeps the reset values of r_h1/r_v1 from posing as position (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h1          <= '0;
      r_v1          <= '0;
      r_en1         <= 1'b0;
      r_s1_vld      <= 1'b0;
      r_de          <= 1'b0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_csync       <= 1'b0;
      r_hblank      <= 1'b0;
      r_vblank      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h1          <= r_hc;
      r_v1          <= r_vc;
      r_en1         <= r_en_q;
      r_s1_vld      <= 1'b1;
      r_de          <= r_s1_vld && !w_hb && !w_vb && r_en1;
      r_hsync       <= r_s1_vld && w_hs;
      r_vsync       <= r_s1_vld && w_vs;
      r_csync       <= r_s1_vld && (w_hs ^ w_vs);
      r_hblank      <= r_s1_vld && w_hb;
      r_vblank      <= r_s1_vld && w_vb;
      r_frame_start <= r_s1_vld && (r_h1 == '0) && (r_v1 == '0);
    end
  end

  assign pix         = r_de ? r_sr[7 -: BPP] : '0;
  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign csync       = r_csync;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_pixie_scaled_back_end.sv
// Bench for pixie_scaled_back_end: a default 1bpp instance and a 2bpp / line-doubled / 8-bit-address instance share the clock, reset and enable.
// Expected outputs come from raster arithmetic on the cycle count since reset release.
module tb_pixie_scaled_back_end;
  localparam int HT    = 112;
  localparam int HA    = 64;
  localparam int HSS   = 80;
  localparam int HSW   = 12;
  localparam int VT    = 262;
  localparam int VA    = 128;
  localparam int VSS   = 182;
  localparam int VSH   = 16;
  localparam int FRAME = HT * VT;
  localparam int BPP_A = 1, VR_A = 1, AW_A = 10;
  localparam int BPP_B = 2, VR_B = 2, AW_B = 8;
  localparam int MAX_FAIL = 50;

  typedef struct packed {
    logic       rd;
    logic [9:0] addr;
    logic [3:0] pix;
    logic       de, hs, vs, cs, hb, vb, fs;
  } obs_t;

  // clock / reset block
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  pixie_scaled_back_end_if #(.FB_AW(AW_A)) fb_a ();
  pixie_scaled_back_end_if #(.FB_AW(AW_B)) fb_b ();

  logic [BPP_A-1:0] pix_a;
  logic [BPP_B-1:0] pix_b;
  logic de_a, hsync_a, vsync_a, csync_a, hblank_a, vblank_a, fs_a;
  logic de_b, hsync_b, vsync_b, csync_b, hblank_b, vblank_b, fs_b;

  pixie_scaled_back_end #(.BPP(BPP_A), .V_REPEAT(VR_A), .FB_AW(AW_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fb(fb_a),
    .pix(pix_a), .de(de_a), .hsync(hsync_a), .vsync(vsync_a), .csync(csync_a),
    .hblank(hblank_a), .vblank(vblank_a), .frame_start(fs_a)
  );

  pixie_scaled_back_end #(.BPP(BPP_B), .V_REPEAT(VR_B), .FB_AW(AW_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fb(fb_b),
    .pix(pix_b), .de(de_b), .hsync(hsync_b), .vsync(vsync_b), .csync(csync_b),
    .hblank(hblank_b), .vblank(vblank_b), .frame_start(fs_b)
  );

  logic [7:0] mem [0:1023];
  bit en_frame [0:7];
  int t;
  int seg;
  int n_tests = 0;
  int n_fail = 0;
  bit pend_a, pend_b;
  int pa_a, pa_b;
  int lit_a [8] = '{1, 1, 1, 0, 0, 1, 0, 0};

  // scoreboard
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s seg=%0d t=%0d actual=%0d required=%0d", name, seg, t, act, exp);
    end
  endtask

  function automatic obs_t model(input int tc, input int bpp, input int vr, input int aw);
    obs_t o;
    int ppb, hc, vc, fr, dh, dv, df, a, b;
    o   = '0;
    ppb = 8 / bpp;
    hc  = tc % HT;
    vc  = (tc / HT) % VT;
    fr  = tc / FRAME;
    o.rd = en_frame[fr] && hc < HA && vc < VA && (hc % ppb) == 0;
    if (o.rd) o.addr = 10'(((vc / vr) * (HA / ppb) + hc / ppb) % (1 << aw));
    if (tc >= 2) begin
      dh   = (tc - 2) % HT;
      dv   = ((tc - 2) / HT) % VT;
      df   = (tc - 2) / FRAME;
      o.hs = dh >= HSS && dh < HSS + HSW;
      o.vs = dv >= VSS && dv < VSS + VSH;
      o.cs = o.hs ^ o.vs;
      o.hb = dh >= HA;
      o.vb = dv >= VA;
      o.fs = dh == 0 && dv == 0;
      o.de = !o.hb && !o.vb && en_frame[df];
      if (o.de) begin
        a     = ((dv / vr) * (HA / ppb) + dh / ppb) % (1 << aw);
        b     = int'(mem[a]);
        o.pix = 4'((b >> (8 - bpp - (dh % ppb) * bpp)) & ((1 << bpp) - 1));
      end
    end
    return o;
  endfunction

  task automatic check_cycle();
    obs_t ea, eb;
    ea = model(t, BPP_A, VR_A, AW_A);
    eb = model(t, BPP_B, VR_B, AW_B);
    chk("a.fb_read_en", int'(fb_a.fb_read_en), int'(ea.rd));
    if (ea.rd) chk("a.fb_addr", int'(fb_a.fb_addr), int'(ea.addr));
    chk("a.pix", int'(pix_a), int'(ea.pix));
    chk("a.de", int'(de_a), int'(ea.de));
    chk("a.hsync", int'(hsync_a), int'(ea.hs));
    chk("a.vsync", int'(vsync_a), int'(ea.vs));
    chk("a.csync", int'(csync_a), int'(ea.cs));
    chk("a.hblank", int'(hblank_a), int'(ea.hb));
    chk("a.vblank", int'(vblank_a), int'(ea.vb));
    chk("a.frame_start", int'(fs_a), int'(ea.fs));
    chk("b.fb_read_en", int'(fb_b.fb_read_en), int'(eb.rd));
    if (eb.rd) chk("b.fb_addr", int'(fb_b.fb_addr), int'(eb.addr));
    chk("b.pix", int'(pix_b), int'(eb.pix));
    chk("b.de", int'(de_b), int'(eb.de));
    chk("b.hsync", int'(hsync_b), int'(eb.hs));
    chk("b.vsync", int'(vsync_b), int'(eb.vs));
    chk("b.csync", int'(csync_b), int'(eb.cs));
    chk("b.hblank", int'(hblank_b), int'(eb.hb));
    chk("b.vblank", int'(vblank_b), int'(eb.vb));
    chk("b.frame_start", int'(fs_b), int'(eb.fs));
  endtask

  task automatic check_zero();
    chk("rst.a.outputs", int'({fb_a.fb_read_en, pix_a, de_a, hsync_a, vsync_a, csync_a, hblank_a, vblank_a, fs_a}), 0);
    chk("rst.a.fb_addr", int'(fb_a.fb_addr), 0);
    chk("rst.b.outputs", int'({fb_b.fb_read_en, pix_b, de_b, hsync_b, vsync_b, csync_b, hblank_b, vblank_b, fs_b}), 0);
    chk("rst.b.fb_addr", int'(fb_b.fb_addr), 0);
  endtask

  // hand-computed anchors (mem[0] = 0xE4)
  task automatic check_literals();
    if (seg == 0) begin
      if (t == 2) chk("lit.a.frame_start", int'(fs_a), 1);
      if (t == 81) chk("lit.a.hsync_before", int'(hsync_a), 0);
      if (t == 82) chk("lit.a.hsync_first", int'(hsync_a), 1);
      if (t == 93) chk("lit.a.hsync_last", int'(hsync_a), 1);
      if (t == 94) chk("lit.a.hsync_after", int'(hsync_a), 0);
      if (t == 182 * HT + 2) chk("lit.a.vsync_first", int'(vsync_a), 1);
      if (t == 197 * HT + 2) chk("lit.a.vsync_last", int'(vsync_a), 1);
      if (t == 198 * HT + 2) chk("lit.a.vsync_after", int'(vsync_a), 0);
      if (t == FRAME) begin
        chk("lit.a.first_strobe", int'(fb_a.fb_read_en), 1);
        chk("lit.a.addr0", int'(fb_a.fb_addr), 0);
      end
      if (t == FRAME + 8) chk("lit.a.addr1", int'(fb_a.fb_addr), 1);
      if (t == FRAME + 56) chk("lit.a.addr7", int'(fb_a.fb_addr), 7);
      if (t == FRAME + 4) chk("lit.b.addr1", int'(fb_b.fb_addr), 1);
      if (t == FRAME + 2) chk("lit.a.de_first", int'(de_a), 1);
      if (t >= FRAME + 2 && t <= FRAME + 9) chk("lit.a.pix_e4", int'(pix_a), lit_a[t - FRAME - 2]);
      if (t >= FRAME + 2 && t <= FRAME + 5) chk("lit.b.pix_e4", int'(pix_b), 3 - (t - FRAME - 2));
      if (t == FRAME + HT) chk("lit.b.line1_repeat", int'(fb_b.fb_addr), 0);
      if (t == FRAME + 2 * HT) begin
        chk("lit.b.line2_addr", int'(fb_b.fb_addr), 16);
        chk("lit.a.line2_addr", int'(fb_a.fb_addr), 16);
      end
      if (t == FRAME + 127 * HT + 56) chk("lit.a.last_addr", int'(fb_a.fb_addr), 1023);
      if (t == FRAME + 127 * HT + 60) chk("lit.b.last_addr_wrap", int'(fb_b.fb_addr), 255);
      if (t == 2 * FRAME + 2) begin
        chk("lit.a.fs_disabled_frame", int'(fs_a), 1);
        chk("lit.a.de_disabled_frame", int'(de_a), 0);
      end
    end else begin
      if (t == 1) chk("lit.a.fs_after_reset_early", int'(fs_a), 0);
      if (t == 2) chk("lit.a.fs_after_reset", int'(fs_a), 1);
      if (t == 82) chk("lit.a.hsync_after_reset", int'(hsync_a), 1);
    end
  endtask

  // driver: framebuffer responses and enable stimulus for the current cycle
  task automatic drive_cycle();
    int line, fr;
    line = (t / HT) % VT;
    fr   = t / FRAME;
    fb_a.fb_data = pend_a ? mem[pa_a] : 8'($urandom);
    fb_b.fb_data = pend_b ? mem[pa_b] : 8'($urandom);
    pend_a = fb_a.fb_read_en;
    pa_a   = int'(fb_a.fb_addr);
    pend_b = fb_b.fb_read_en;
    pa_b   = int'(fb_b.fb_addr);
    if ((t % HT) == 0 || (t % HT) == 37) enable = 1'($urandom_range(0, 1));
    if (seg == 0) begin
      if (fr == 0 && line == VT - 1) enable = 1'b1;
      if (fr == 1 && line < 50) enable = 1'b1;
      if (fr == 1 && line == 50) enable = 1'b0;
      if (fr == 1 && line == VT - 1) enable = 1'b0;
    end
    if ((t % FRAME) == FRAME - 1) en_frame[fr + 1] = enable;
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    t = 0;
    for (int i = 0; i < 8; i++) en_frame[i] = 1'b0;
    pend_a = 1'b0;
    pend_b = 1'b0;
    #1;
    check_cycle();
  endtask

  initial begin
    int stop_t;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE4;
    fb_a.fb_data = 8'h00;
    fb_b.fb_data = 8'h00;
    seg = 0;
    t = 0;
    #2 reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero();
    end
    for (int s = 0; s < 2; s++) begin
      seg = s;
      stop_t = (s == 0) ? (2 * FRAME + 10 * HT + 40) : (3 * HT);
      release_reset();
      while (t != stop_t && n_fail < MAX_FAIL) begin
        drive_cycle();
        @(negedge clk);
        t++;
        check_cycle();
        check_literals();
      end
      if (n_fail >= MAX_FAIL) break;
      if (s == 0) begin
        reset_n = 1'b0;
        #1;
        check_zero();
        repeat (3) begin
          @(negedge clk);
          check_zero();
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
